// File: rtl/pipeline_exb_bp_stage_pkg.sv
// exb_bp_pkg: shared types and helpers for the EXB branch-resolution stage.
//   br_type_e  : funct3 encodings of the conditional branches
//   CTR_*      : 2-bit saturating counter states of the branch history table
//   sat_update : next counter value for a resolved branch outcome
package exb_bp_pkg;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_type_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Count up on taken, down on not-taken, saturating at both ends.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && ctr != CTR_ST) begin
      res = ctr + 2'd1;
    end else if (!taken && ctr != CTR_SNT) begin
      res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pipeline_exb_bp_stage_if.sv
// pipeline_exb_bp_stage_if: IDR-side instruction bundle into the EXB stage and
// the registered EXA-facing bundle out of it.
//   master : drives the *_IDR signals, observes the *_EXB signals
//   slave  : the EXB stage itself
interface pipeline_exb_bp_stage_if #(
  parameter int XLEN      = 64,
  parameter int PAYLOAD_W = 16
);
  import exb_bp_pkg::*;

  // IDR side
  logic                 valid_IDR;
  logic [XLEN-1:0]      pc_IDR;
  logic [XLEN-1:0]      reg_data1_IDR;
  logic [XLEN-1:0]      reg_data2_IDR;
  logic [XLEN-1:0]      imm_IDR;
  logic                 is_branch_IDR;
  logic                 is_jal_IDR;
  logic                 is_jalr_IDR;
  logic [2:0]           BrType_IDR;
  logic                 pred_taken_IDR;
  logic [XLEN-1:0]      pred_target_IDR;
  logic [PAYLOAD_W-1:0] payload_IDR;

  // EXA-facing pipeline register
  logic                 valid_EXB;
  logic [XLEN-1:0]      pc_EXB;
  logic [XLEN-1:0]      reg_data1_EXB;
  logic [XLEN-1:0]      reg_data2_EXB;
  logic [XLEN-1:0]      imm_EXB;
  logic [PAYLOAD_W-1:0] payload_EXB;

  modport master (
    output valid_IDR, pc_IDR, reg_data1_IDR, reg_data2_IDR, imm_IDR,
           is_branch_IDR, is_jal_IDR, is_jalr_IDR, BrType_IDR,
           pred_taken_IDR, pred_target_IDR, payload_IDR,
    input  valid_EXB, pc_EXB, reg_data1_EXB, reg_data2_EXB, imm_EXB, payload_EXB
  );

  modport slave (
    input  valid_IDR, pc_IDR, reg_data1_IDR, reg_data2_IDR, imm_IDR,
           is_branch_IDR, is_jal_IDR, is_jalr_IDR, BrType_IDR,
           pred_taken_IDR, pred_target_IDR, payload_IDR,
    output valid_EXB, pc_EXB, reg_data1_EXB, reg_data2_EXB, imm_EXB, payload_EXB
  );

endinterface

// File: rtl/pipeline_exb_bp_stage_bht.sv
// branch_bht: branch history table of DEPTH 2-bit saturating counters.
//   clk, reset           : clock, asynchronous active-low reset (entries -> CTR_WNT)
//   rd_idx_i / rd_ctr_o  : combinational read port (old value during a same-index write)
//   wr_en_i, wr_idx_i,
//   wr_taken_i           : read-modify-write training port, applied at the clock edge
module branch_bht
  import exb_bp_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_ctr_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  logic [1:0] ctr_all [DEPTH];

  // One flop pair per entry; the training port does the saturating update
  // itself so the stage needs no second read port.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [1:0] ctr_q;
    logic [1:0] ctr_d;

    always_comb begin
      ctr_d = ctr_q;
      if (wr_en_i && wr_idx_i == IDX_W'(gi)) begin
        ctr_d = sat_update(ctr_q, wr_taken_i);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ctr_q <= CTR_WNT;
      end else begin
        ctr_q <= ctr_d;
      end
    end

    assign ctr_all[gi] = ctr_q;
  end

  assign rd_ctr_o = ctr_all[rd_idx_i];

endmodule

// File: rtl/pipeline_exb_bp_stage.sv
// pipeline_exb_bp_stage: EXB branch-resolution stage with integrated BHT.
//   clk, reset          : clock, asynchronous active-low reset
//   flush, stall        : pipeline control (flush wins over stall)
//   bus (slave)         : IDR instruction in, registered EXA-facing bundle out
//   lookup_pc_IF /
//   lookup_taken_IF     : combinational prediction read for IF
//   redirect_EXB /
//   redirect_pc_EXB     : same-cycle misprediction redirect and correct next PC
//   stat_branches /
//   stat_mispredicts    : resolved control transfers and mispredictions
module pipeline_exb_bp_stage
  import exb_bp_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int BHT_DEPTH = 256,
  parameter int PAYLOAD_W = 16,
  parameter int CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  stall,
  pipeline_exb_bp_stage_if.slave bus,
  input  logic [XLEN-1:0]       lookup_pc_IF,
  output logic                  lookup_taken_IF,
  output logic                  redirect_EXB,
  output logic [XLEN-1:0]       redirect_pc_EXB,
  output logic [CNT_W-1:0]      stat_branches,
  output logic [CNT_W-1:0]      stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic            fire;
  logic            cond;
  logic            actual_taken;
  logic [XLEN-1:0] target;
  logic            mispredict;
  logic [1:0]      lookup_ctr;
  logic            unused_lookup_bits;

  // Only instructions that truly leave IDR this cycle may act.
  assign fire = bus.valid_IDR & ~stall & ~flush;

  always_comb begin
    cond = 1'b0;
    case (br_type_e'(bus.BrType_IDR))
      BR_EQ:   cond = (bus.reg_data1_IDR == bus.reg_data2_IDR);
      BR_NE:   cond = (bus.reg_data1_IDR != bus.reg_data2_IDR);
      BR_LT:   cond = ($signed(bus.reg_data1_IDR) <  $signed(bus.reg_data2_IDR));
      BR_GE:   cond = ($signed(bus.reg_data1_IDR) >= $signed(bus.reg_data2_IDR));
      BR_LTU:  cond = (bus.reg_data1_IDR <  bus.reg_data2_IDR);
      BR_GEU:  cond = (bus.reg_data1_IDR >= bus.reg_data2_IDR);
      default: cond = 1'b0;  // 010 / 011 are never taken
    endcase
  end

  assign actual_taken = (bus.is_branch_IDR & cond) | bus.is_jal_IDR | bus.is_jalr_IDR;

  // JALR clears bit 0 of the computed address.
  assign target = bus.is_jalr_IDR
                ? ((bus.reg_data1_IDR + bus.imm_IDR) & ~{{(XLEN-1){1'b0}}, 1'b1})
                : (bus.pc_IDR + bus.imm_IDR);

  // A correct taken prediction must also have guessed the right target.
  assign mispredict = (actual_taken != bus.pred_taken_IDR)
                    | (actual_taken & bus.pred_taken_IDR & (target != bus.pred_target_IDR));

  assign redirect_EXB    = fire & mispredict;
  assign redirect_pc_EXB = actual_taken ? target : (bus.pc_IDR + XLEN'(4));

  branch_bht #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk        (clk),
    .reset      (reset),
    .rd_idx_i   (lookup_pc_IF[IDX_W+1:2]),
    .rd_ctr_o   (lookup_ctr),
    .wr_en_i    (fire & bus.is_branch_IDR),
    .wr_idx_i   (bus.pc_IDR[IDX_W+1:2]),
    .wr_taken_i (actual_taken)
  );

  assign lookup_taken_IF    = lookup_ctr[1];
  assign unused_lookup_bits = ^{lookup_pc_IF[XLEN-1:IDX_W+2], lookup_pc_IF[1:0], lookup_ctr[0]};

  // Statistics
  logic [CNT_W-1:0] stat_br_q, stat_br_d;
  logic [CNT_W-1:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (fire && (bus.is_branch_IDR || bus.is_jal_IDR || bus.is_jalr_IDR)) begin
      stat_br_d = stat_br_q + CNT_W'(1);
    end
    if (redirect_EXB) begin
      stat_mp_d = stat_mp_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

  // EXA-facing pipeline register
  logic                 valid_q;
  logic [XLEN-1:0]      pc_q, d1_q, d2_q, imm_q;
  logic [PAYLOAD_W-1:0] pay_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      imm_q   <= '0;
      pay_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      imm_q   <= '0;
      pay_q   <= '0;
    end else if (!stall) begin
      valid_q <= bus.valid_IDR;
      pc_q    <= bus.pc_IDR;
      d1_q    <= bus.reg_data1_IDR;
      d2_q    <= bus.reg_data2_IDR;
      imm_q   <= bus.imm_IDR;
      pay_q   <= bus.payload_IDR;
    end
  end

  assign bus.valid_EXB     = valid_q;
  assign bus.pc_EXB        = pc_q;
  assign bus.reg_data1_EXB = d1_q;
  assign bus.reg_data2_EXB = d2_q;
  assign bus.imm_EXB       = imm_q;
  assign bus.payload_EXB   = pay_q;

endmodule

// File: tb/tb_pipeline_exb_bp_stage.sv
// Directed-vector bench for pipeline_exb_bp_stage with a due-cycle scoreboard:
// the stimulus pushes expected values tagged with the cycle they should
// appear in, and a negedge monitor checks every item whose cycle has come.
module tb_pipeline_exb_bp_stage;

  localparam int XLEN = 64;
  localparam int PW   = 16;
  localparam int CW   = 32;

  localparam int K_REDIR = 0, K_RPC = 1, K_LOOK = 2, K_VALID = 3, K_PC = 4,
                 K_D1 = 5, K_D2 = 6, K_IMM = 7, K_PAY = 8, K_SB = 9, K_SM = 10;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic            stall = 1'b0;
  logic [XLEN-1:0] lookup_pc = '0;
  logic            lookup_taken;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [CW-1:0]   stat_br, stat_mp;

  pipeline_exb_bp_stage_if #(.XLEN(XLEN), .PAYLOAD_W(PW)) bus ();

  pipeline_exb_bp_stage #(
    .XLEN(XLEN), .BHT_DEPTH(256), .PAYLOAD_W(PW), .CNT_W(CW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .stall            (stall),
    .bus              (bus),
    .lookup_pc_IF     (lookup_pc),
    .lookup_taken_IF  (lookup_taken),
    .redirect_EXB     (redirect),
    .redirect_pc_EXB  (redirect_pc),
    .stat_branches    (stat_br),
    .stat_mispredicts (stat_mp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    int          due;
    logic [63:0] val;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] actual(int k);
    case (k)
      K_REDIR: return {63'b0, redirect};
      K_RPC:   return redirect_pc;
      K_LOOK:  return {63'b0, lookup_taken};
      K_VALID: return {63'b0, bus.valid_EXB};
      K_PC:    return bus.pc_EXB;
      K_D1:    return bus.reg_data1_EXB;
      K_D2:    return bus.reg_data2_EXB;
      K_IMM:   return bus.imm_EXB;
      K_PAY:   return {48'b0, bus.payload_EXB};
      K_SB:    return {32'b0, stat_br};
      K_SM:    return {32'b0, stat_mp};
      default: return 64'hDEAD;
    endcase
  endfunction

  // Monitor
  always @(negedge clk) begin
    int i;
    logic [63:0] a;
    i = 0;
    while (i < sb_q.size()) begin
      if (sb_q[i].due == cyc) begin
        a = actual(sb_q[i].kind);
        checks++;
        if (a !== sb_q[i].val) begin
          errors++;
          $display("FAIL %s (cycle %0d): got %h expected %h", sb_q[i].nm, cyc, a, sb_q[i].val);
        end else begin
          $display("ok   %s (cycle %0d): %h", sb_q[i].nm, cyc, a);
        end
        sb_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic e(input int k, input logic [63:0] v, input int d, input string nm);
    sb_q.push_back('{k, cyc + d, v, nm});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.valid_IDR     = 1'b0;
    bus.is_branch_IDR = 1'b0;
    bus.is_jal_IDR    = 1'b0;
    bus.is_jalr_IDR   = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic instr(input logic [63:0] pc, input logic [63:0] d1, input logic [63:0] d2,
                       input logic [63:0] imm, input logic br, input logic jal, input logic jalr,
                       input logic [2:0] bt, input logic pt, input logic [63:0] ptg,
                       input logic [15:0] pay);
    bus.valid_IDR       = 1'b1;
    bus.pc_IDR          = pc;
    bus.reg_data1_IDR   = d1;
    bus.reg_data2_IDR   = d2;
    bus.imm_IDR         = imm;
    bus.is_branch_IDR   = br;
    bus.is_jal_IDR      = jal;
    bus.is_jalr_IDR     = jalr;
    bus.BrType_IDR      = bt;
    bus.pred_taken_IDR  = pt;
    bus.pred_target_IDR = ptg;
    bus.payload_IDR     = pay;
  endtask

  // Register contents expected one cycle after a normal load.
  task automatic exb(input logic [63:0] pc, input logic [63:0] d1, input logic [63:0] d2,
                     input logic [63:0] imm, input logic [15:0] pay);
    e(K_VALID, 64'd1, 1, "valid_EXB");
    e(K_PC,    pc,    1, "pc_EXB");
    e(K_D1,    d1,    1, "reg_data1_EXB");
    e(K_D2,    d2,    1, "reg_data2_EXB");
    e(K_IMM,   imm,   1, "imm_EXB");
    e(K_PAY,   {48'b0, pay}, 1, "payload_EXB");
  endtask

  initial begin
    idle();
    instr(64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 64'h0, 16'h0);
    bus.valid_IDR = 1'b0;
    lookup_pc = 64'h100;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state
    e(K_LOOK, 0, 0, "reset lookup");
    e(K_REDIR, 0, 0, "reset redirect");
    e(K_VALID, 0, 0, "reset valid_EXB");
    e(K_SB, 0, 0, "reset stat_branches");
    e(K_SM, 0, 0, "reset stat_mispredicts");
    tick();

    // BEQ taken, predicted not-taken
    instr(64'h100, 64'd5, 64'd5, 64'h40, 1, 0, 0, 3'b000, 0, 64'h0, 16'hA1);
    e(K_REDIR, 1, 0, "beq redirect");
    e(K_RPC, 64'h140, 0, "beq redirect_pc");
    e(K_LOOK, 0, 0, "beq same-cycle lookup");
    exb(64'h100, 64'd5, 64'd5, 64'h40, 16'hA1);
    e(K_SB, 1, 1, "beq stat_branches");
    e(K_SM, 1, 1, "beq stat_mispredicts");
    e(K_LOOK, 1, 1, "beq next-cycle lookup");
    tick();
    idle();
    e(K_REDIR, 0, 0, "idle redirect");
    tick();

    // BLTU not taken against a taken prediction
    lookup_pc = 64'h200;
    instr(64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 1, 0, 0, 3'b110, 1, 64'h220, 16'hB2);
    e(K_LOOK, 0, 0, "bltu lookup");
    e(K_REDIR, 1, 0, "bltu redirect");
    e(K_RPC, 64'h204, 0, "bltu redirect_pc");
    exb(64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 16'hB2);
    e(K_SB, 2, 1, "bltu stat_branches");
    e(K_SM, 2, 1, "bltu stat_mispredicts");
    tick();

    // Same operands as BLT: taken, correctly predicted
    instr(64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 1, 0, 0, 3'b100, 1, 64'h220, 16'hB3);
    e(K_REDIR, 0, 0, "blt redirect");
    e(K_LOOK, 0, 0, "blt lookup after decrement");
    exb(64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 16'hB3);
    e(K_SB, 3, 1, "blt stat_branches");
    e(K_SM, 2, 1, "blt stat_mispredicts");
    tick();

    // JALR with bit 0 cleared, correctly predicted; table untouched
    lookup_pc = 64'h300;
    instr(64'h300, 64'h2001, 64'h0, 64'h10, 0, 0, 1, 3'b000, 1, 64'h2010, 16'hC4);
    e(K_REDIR, 0, 0, "jalr redirect");
    exb(64'h300, 64'h2001, 64'h0, 64'h10, 16'hC4);
    e(K_SB, 4, 1, "jalr stat_branches");
    e(K_SM, 2, 1, "jalr stat_mispredicts");
    tick();
    idle();
    e(K_LOOK, 0, 0, "jalr bht unchanged");
    e(K_REDIR, 0, 0, "idle redirect");
    tick();

    // JAL predicted not-taken
    instr(64'h400, 64'h0, 64'h0, 64'h100, 0, 1, 0, 3'b000, 0, 64'h0, 16'hD5);
    e(K_REDIR, 1, 0, "jal redirect");
    e(K_RPC, 64'h500, 0, "jal redirect_pc");
    exb(64'h400, 64'h0, 64'h0, 64'h100, 16'hD5);
    e(K_SB, 5, 1, "jal stat_branches");
    e(K_SM, 3, 1, "jal stat_mispredicts");
    tick();

    // Five taken BNEs at one PC: 01 -> 10 -> 11 -> 11 -> 11 -> 11
    lookup_pc = 64'h504;
    for (int k = 0; k < 5; k++) begin
      instr(64'h504, 64'd1, 64'd2, 64'h8, 1, 0, 0, 3'b001, 1, 64'h50C, 16'hE0 + 16'(k));
      e(K_REDIR, 0, 0, "bne-taken redirect");
      e(K_LOOK, (k == 0) ? 64'd0 : 64'd1, 0, "bne-taken lookup");
      exb(64'h504, 64'd1, 64'd2, 64'h8, 16'hE0 + 16'(k));
      e(K_SB, 64'(6 + k), 1, "bne-taken stat_branches");
      tick();
    end

    // Two not-taken BNEs: 11 -> 10 -> 01
    instr(64'h504, 64'd3, 64'd3, 64'h8, 1, 0, 0, 3'b001, 0, 64'h0, 16'hF0);
    e(K_LOOK, 1, 0, "saturated lookup");
    e(K_REDIR, 0, 0, "bne-nt redirect");
    e(K_SB, 11, 1, "bne-nt stat_branches");
    tick();
    instr(64'h504, 64'd3, 64'd3, 64'h8, 1, 0, 0, 3'b001, 0, 64'h0, 16'hF1);
    e(K_LOOK, 1, 0, "after one nt lookup");
    e(K_REDIR, 0, 0, "bne-nt redirect");
    e(K_SB, 12, 1, "bne-nt stat_branches");
    tick();

    // Mispredicting BEQ held under stall for three cycles
    instr(64'h600, 64'd7, 64'd7, 64'h10, 1, 0, 0, 3'b000, 0, 64'h0, 16'h0077);
    stall = 1'b1;
    e(K_LOOK, 0, 0, "after two nt lookup");
    for (int k = 0; k < 3; k++) begin
      e(K_REDIR, 0, 0, "stalled redirect");
      e(K_SB, 12, 1, "stalled stat_branches");
      e(K_SM, 3, 1, "stalled stat_mispredicts");
      e(K_VALID, 1, 1, "stalled valid_EXB hold");
      e(K_PC, 64'h504, 1, "stalled pc_EXB hold");
      e(K_PAY, 64'hF1, 1, "stalled payload_EXB hold");
      tick();
    end
    stall = 1'b0;
    e(K_REDIR, 1, 0, "released redirect");
    e(K_RPC, 64'h610, 0, "released redirect_pc");
    e(K_SB, 13, 1, "released stat_branches");
    e(K_SM, 4, 1, "released stat_mispredicts");
    exb(64'h600, 64'd7, 64'd7, 64'h10, 16'h0077);
    tick();

    // Flush together with stall: bubble loads, no side effects
    instr(64'h800, 64'd1, 64'd2, 64'h8, 1, 0, 0, 3'b001, 0, 64'h0, 16'h0088);
    stall = 1'b1;
    flush = 1'b1;
    e(K_REDIR, 0, 0, "flush redirect");
    e(K_VALID, 0, 1, "flush valid_EXB");
    e(K_PC, 0, 1, "flush pc_EXB");
    e(K_PAY, 0, 1, "flush payload_EXB");
    e(K_SB, 13, 1, "flush stat_branches");
    e(K_SM, 4, 1, "flush stat_mispredicts");
    tick();
    stall = 1'b0;
    flush = 1'b0;

    // Reserved funct3 010 never taken
    lookup_pc = 64'h700;
    instr(64'h700, 64'd3, 64'd3, 64'h8, 1, 0, 0, 3'b010, 1, 64'h708, 16'h0099);
    e(K_REDIR, 1, 0, "br010 redirect");
    e(K_RPC, 64'h704, 0, "br010 redirect_pc");
    exb(64'h700, 64'd3, 64'd3, 64'h8, 16'h0099);
    e(K_SB, 14, 1, "br010 stat_branches");
    e(K_SM, 5, 1, "br010 stat_mispredicts");
    tick();
    idle();
    e(K_LOOK, 0, 0, "br010 lookup");
    e(K_REDIR, 0, 0, "idle redirect");
    tick();

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) tick();
    if (sb_q.size() != 0) begin
      errors += sb_q.size();
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
